// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped UART transmitter, FIFO-fed 8N1 serialiser.
// Define MMIO_UART_TX_PARITY_EN for 8E1 frames (even parity bit).
package mmio_uart_tx_pkg;
  typedef enum logic [2:0] {
    MEM_B,
    MEM_H,
    MEM_W,
    MEM_BU,
    MEM_HU
  } mem_dt_e;
endpackage

module mmio_uart_tx
  import mmio_uart_tx_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DEF_DIV    = 16'd434
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wd,
  input  logic        d_we,
  input  mem_dt_e     d_dt,
  output logic [31:0] d_rd,
  output logic        sel,
  output logic        tx,
  output logic        irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
`ifdef MMIO_UART_TX_PARITY_EN
    , S_PAR
`endif
  } state_e;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [CW-1:0] fcnt_q;
  logic          ovf_q;
  logic [15:0]   div_q;

  state_e        st_q;
  logic          tx_q;
  logic [15:0]   bc_q;
  logic [15:0]   dl_q;
  logic [2:0]    bi_q;
  logic [7:0]    sh_q;
`ifdef MMIO_UART_TX_PARITY_EN
  logic          par_q;
`endif

  logic          wr;
  logic [1:0]    off;
  logic          empty, full, busy, last;
  logic          push_req, push, pop;
  logic [7:0]    head;
  logic [15:0]   div_eff;
  logic [31:0]   status;
  logic          unused_bits;

  assign sel      = d_addr[31:4] == BASE_ADDR[31:4];
  assign wr       = sel & d_we;
  assign off      = d_addr[3:2];
  assign empty    = fcnt_q == '0;
  assign full     = fcnt_q == CW'(FIFO_DEPTH);
  assign busy     = st_q != S_IDLE;
  assign last     = bc_q == dl_q - 16'd1;
  assign head     = mem_q[rp_q];
  assign div_eff  = (div_q == 16'd0) ? 16'd1 : div_q;
  assign push_req = wr & (off == 2'd0);
  assign pop      = !empty &
                    ((st_q == S_IDLE) |
                     ((st_q == S_STOP) & last));
  assign push     = push_req & (!full | pop);

  assign tx  = tx_q;
  assign irq = empty & !busy;

  assign status = {23'd0, 5'(fcnt_q),
                   ovf_q, empty, full, busy};

  // Access width is irrelevant: every register takes the full word lanes.
  assign unused_bits = ^{d_dt, d_addr[1:0], d_wd[31:16]};

  always_comb begin
    d_rd = '0;
    if (sel) begin
      unique case (off)
        2'd0: d_rd = '0;
        2'd1: d_rd = status;
        2'd2: d_rd = {16'd0, div_q};
        2'd3: d_rd = '0;
        default: d_rd = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q   <= '0;
      rp_q   <= '0;
      fcnt_q <= '0;
      ovf_q  <= 1'b0;
      div_q  <= DEF_DIV;
    end else begin
      if (push) wp_q <= wp_q + AW'(1);
      if (pop)  rp_q <= rp_q + AW'(1);
      if (push & !pop)
        fcnt_q <= fcnt_q + CW'(1);
      else if (pop & !push)
        fcnt_q <= fcnt_q - CW'(1);
      if (push_req & full & !pop)
        ovf_q <= 1'b1;
      else if (wr & (off == 2'd1) & d_wd[3])
        ovf_q <= 1'b0;
      if (wr & (off == 2'd2))
        div_q <= d_wd[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= d_wd[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q  <= S_IDLE;
      tx_q  <= 1'b1;
      bc_q  <= '0;
      dl_q  <= 16'd1;
      bi_q  <= '0;
      sh_q  <= '0;
`ifdef MMIO_UART_TX_PARITY_EN
      par_q <= 1'b0;
`endif
    end else begin
      bc_q <= last ? '0 : bc_q + 16'd1;
      unique case (st_q)
        S_IDLE: begin
          bc_q <= '0;
          if (!empty) begin
            st_q <= S_START;
            tx_q <= 1'b0;
            sh_q <= head;
            dl_q <= div_eff;
`ifdef MMIO_UART_TX_PARITY_EN
            par_q <= ^head;
`endif
          end
        end
        S_START: begin
          if (last) begin
            st_q <= S_DATA;
            tx_q <= sh_q[0];
            sh_q <= sh_q >> 1;
            bi_q <= '0;
          end
        end
        S_DATA: begin
          if (last) begin
            if (bi_q == 3'd7) begin
`ifdef MMIO_UART_TX_PARITY_EN
              st_q <= S_PAR;
              tx_q <= par_q;
`else
              st_q <= S_STOP;
              tx_q <= 1'b1;
`endif
            end else begin
              tx_q <= sh_q[0];
              sh_q <= sh_q >> 1;
              bi_q <= bi_q + 3'd1;
            end
          end
        end
`ifdef MMIO_UART_TX_PARITY_EN
        S_PAR: begin
          if (last) begin
            st_q <= S_STOP;
            tx_q <= 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (last) begin
            if (!empty) begin
              st_q <= S_START;
              tx_q <= 1'b0;
              sh_q <= head;
              dl_q <= div_eff;
`ifdef MMIO_UART_TX_PARITY_EN
              par_q <= ^head;
`endif
            end else begin
              st_q <= S_IDLE;
            end
          end
        end
        default: begin
          st_q <= S_IDLE;
          tx_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: directed + random frames against a
// bit-list reference model of the serial line.
module tb_mmio_uart_tx;
  import mmio_uart_tx_pkg::*;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam logic [31:0] A_TX = BASE;
  localparam logic [31:0] A_ST = BASE + 32'h4;
  localparam logic [31:0] A_DV = BASE + 32'h8;
  localparam logic [31:0] A_RS = BASE + 32'hC;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wd = '0;
  logic        d_we = 1'b0;
  mem_dt_e     d_dt = MEM_W;
  logic [31:0] d_rd;
  logic        sel, tx, irq;

  int tests = 0;
  int fails = 0;

  mmio_uart_tx #(
    .BASE_ADDR (BASE),
    .FIFO_DEPTH(8),
    .DEF_DIV   (16'd434)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .d_addr(d_addr),
    .d_wd  (d_wd),
    .d_we  (d_we),
    .d_dt  (d_dt),
    .d_rd  (d_rd),
    .sel   (sel),
    .tx    (tx),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h",
             tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic wr(input logic [31:0] a,
                    input logic [31:0] d);
    d_addr = a;
    d_wd   = d;
    d_we   = 1'b1;
    @(negedge clk);
    d_we   = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a,
                    output logic [31:0] v);
    d_addr = a;
    d_we   = 1'b0;
    #1;
    v = d_rd;
  endtask

  // Expected line: one frame per byte, each bit held div clocks.
  task automatic check_line(input logic [7:0] q[$],
                            input int div,
                            input string tag);
    bit eb[$];
    int de;
    int bad;
    de  = (div == 0) ? 1 : div;
    bad = 0;
    foreach (q[k]) begin
      eb.push_back(1'b0);
      for (int i = 0; i < 8; i++) eb.push_back(q[k][i]);
`ifdef MMIO_UART_TX_PARITY_EN
      eb.push_back(^q[k]);
`endif
      eb.push_back(1'b1);
    end
    foreach (eb[j]) begin
      for (int c = 0; c < de; c++) begin
        @(negedge clk);
        if (tx !== eb[j]) bad++;
      end
    end
    chk(tag, 32'(bad), 32'd0);
  endtask

  task automatic send(input logic [7:0] q[$],
                      input int div,
                      input string tag);
    wr(A_TX, {24'd0, q[0]});
    fork
      for (int k = 1; k < q.size(); k++)
        wr(A_TX, {24'd0, q[k]});
      check_line(q, div, tag);
    join
  endtask

  initial begin
    logic [31:0] v;
    logic [7:0]  q[$];
    int          dv;
    int          n;

    repeat (2) @(negedge clk);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_irq", 32'(irq), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);
    rd(A_ST, v);
    chk("rst_status", v, 32'h004);
    rd(A_DV, v);
    chk("rst_div", v, 32'd434);
    chk("rst_sel", 32'(sel), 32'd1);

    // Basic 0x55 frame at divisor 4.
    @(negedge clk);
    wr(A_DV, 32'd4);
    q = '{8'h55};
    send(q, 4, "t1_frame");
    @(negedge clk);
    chk("t1_irq", 32'(irq), 32'd1);

    // FIFO fill, overflow and sticky clear.
    wr(A_DV, 32'd100);
    for (int i = 0; i < 9; i++)
      wr(A_TX, 32'(8'h10 + i));
    rd(A_ST, v);
    chk("t2_full", v, 32'h083);
    chk("t2_tx_start", 32'(tx), 32'd0);
    chk("t2_irq", 32'(irq), 32'd0);
    @(negedge clk);
    wr(A_TX, 32'h99);
    rd(A_ST, v);
    chk("t2_ovf", v, 32'h08B);
    @(negedge clk);
    wr(A_ST, 32'h8);
    rd(A_ST, v);
    chk("t2_ovf_clr", v, 32'h083);
    @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Back-to-back frames, no idle gap.
    wr(A_DV, 32'd3);
    q = '{8'hA5, 8'h3C};
    send(q, 3, "t3_b2b");
    @(negedge clk);
    chk("t3_irq", 32'(irq), 32'd1);

    // Asynchronous reset mid-DATA with 3 queued.
    wr(A_DV, 32'd20);
    wr(A_TX, 32'h00);
    for (int i = 0; i < 3; i++)
      wr(A_TX, 32'hF0 + 32'(i));
    repeat (27) @(negedge clk);
    chk("t4_pre_tx", 32'(tx), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("t4_async_tx", 32'(tx), 32'd1);
    chk("t4_async_irq", 32'(irq), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rd(A_ST, v);
    chk("t4_status", v, 32'h004);
    rd(A_DV, v);
    chk("t4_div", v, 32'd434);

    // Divisor 0 behaves as 1.
    @(negedge clk);
    wr(A_DV, 32'd0);
    q = '{8'hFF};
    send(q, 0, "t5_div0");
`ifdef MMIO_UART_TX_PARITY_EN
    q = '{8'h07};
    send(q, 0, "t5_par1");
    q = '{8'h03};
    send(q, 0, "t5_par0");
`endif
    @(negedge clk);
    chk("t5_irq", 32'(irq), 32'd1);

    // Random frames against the line model.
    for (int it = 0; it < 6; it++) begin
      dv = $urandom_range(0, 5);
      n  = $urandom_range(1, 3);
      q  = {};
      for (int k = 0; k < n; k++)
        q.push_back(8'($urandom));
      wr(A_DV, 32'(dv));
      send(q, dv, $sformatf("rnd%0d", it));
      @(negedge clk);
      rd(A_ST, v);
      chk($sformatf("rnd%0d_st", it), v, 32'h004);
      @(negedge clk);
    end

    // Decode edges and byte store to DIVISOR.
    rd(A_RS, v);
    chk("t6_rsv_rd", v, 32'd0);
    chk("t6_rsv_sel", 32'(sel), 32'd1);
    rd(BASE + 32'h10, v);
    chk("t6_out_rd", v, 32'd0);
    chk("t6_out_sel", 32'(sel), 32'd0);
    @(negedge clk);
    d_dt = MEM_B;
    wr(A_DV, 32'hFFFF_ABCD);
    d_dt = MEM_W;
    rd(A_DV, v);
    chk("t6_byte_div", v, 32'h0000_ABCD);
    @(negedge clk);
    wr(A_RS, 32'h1234);
    rd(A_DV, v);
    chk("t6_rsv_wr", v, 32'h0000_ABCD);
    @(negedge clk);
    wr(BASE + 32'h10, 32'h41);
    repeat (3) @(negedge clk);
    rd(A_ST, v);
    chk("t6_out_wr", v, 32'h004);
    chk("t6_out_tx", 32'(tx), 32'd1);

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
